reg_writeback_unit: RTL and testbench

- Writer side of the register-file write port (rd_w / writeData / regWrite); sits at the end of the MIPS pipeline as the MEM/WB stage.
- Captures retiring instructions, selects the ALU result or load data, and drives a one-cycle register-file write.
- Handles loads whose data-memory response arrives late: stalls upstream until mem_ready, then writes.
- Exposes a forwarding tap for the decode/execute hazard logic.

---
 rtl/reg_writeback_unit.sv | 110 +++++++++++
 tb/tb_reg_writeback_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_unit.sv
// MEM/WB writeback stage: drives the register-file write port, waits on late load data.
// Optional macro WB_TIMEOUT_EN adds a WAIT_MEM timeout with sticky timeout_err.
module reg_writeback_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_regWrite,
  input  logic        in_memToReg,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_aluResult,
  input  logic        mem_ready,
  input  logic [31:0] mem_readData,
  output logic        stall,
  output logic [4:0]  rd_w,
  output logic [31:0] writeData,
  output logic        regWrite,
  output logic        fwd_valid,
  output logic [4:0]  fwd_reg,
  output logic [31:0] fwd_data
`ifdef WB_TIMEOUT_EN
  ,
  output logic        timeout_err
`endif
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("reg_writeback_unit: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t      state;
  logic [4:0]  pend_rd;
  logic        accept;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wait_cnt;
`endif

  // $0 and non-writing instructions never reach the register file
  assign accept = in_valid && in_regWrite && (in_rd != 5'd0);
  assign stall  = (state == WAIT_MEM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pend_rd     <= 5'd0;
      rd_w        <= 5'd0;
      writeData   <= 32'd0;
      regWrite    <= 1'b0;
      fwd_valid   <= 1'b0;
      fwd_reg     <= 5'd0;
      fwd_data    <= 32'd0;
`ifdef WB_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      regWrite  <= 1'b0;
      fwd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_memToReg) begin
              pend_rd <= in_rd;
              state   <= WAIT_MEM;
`ifdef WB_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              regWrite  <= 1'b1;
              rd_w      <= in_rd;
              writeData <= in_aluResult;
              fwd_valid <= 1'b1;
              fwd_reg   <= in_rd;
              fwd_data  <= in_aluResult;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_ready) begin
            regWrite  <= 1'b1;
            rd_w      <= pend_rd;
            writeData <= mem_readData;
            fwd_valid <= 1'b1;
            fwd_reg   <= pend_rd;
            fwd_data  <= mem_readData;
            state     <= IDLE;
`ifdef WB_TIMEOUT_EN
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Give up on the load: flag it and drop the write
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Self-checking bench for reg_writeback_unit: directed scenarios plus a randomized
// run against a transaction-level model. Covers WB_TIMEOUT_EN when defined.
module tb_reg_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_regWrite;
  logic        in_memToReg;
  logic [4:0]  in_rd;
  logic [31:0] in_aluResult;
  logic        mem_ready;
  logic [31:0] mem_readData;
  logic        stall;
  logic [4:0]  rd_w;
  logic [31:0] writeData;
  logic        regWrite;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
`ifdef WB_TIMEOUT_EN
  logic        timeout_err;
`endif

  int total = 0;
  int bad   = 0;

  reg_writeback_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_regWrite  (in_regWrite),
    .in_memToReg  (in_memToReg),
    .in_rd        (in_rd),
    .in_aluResult (in_aluResult),
    .mem_ready    (mem_ready),
    .mem_readData (mem_readData),
    .stall        (stall),
    .rd_w         (rd_w),
    .writeData    (writeData),
    .regWrite     (regWrite),
    .fwd_valid    (fwd_valid),
    .fwd_reg      (fwd_reg),
    .fwd_data     (fwd_data)
`ifdef WB_TIMEOUT_EN
    ,
    .timeout_err  (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle_inputs;
    in_valid     = 1'b0;
    in_regWrite  = 1'b0;
    in_memToReg  = 1'b0;
    in_rd        = 5'd0;
    in_aluResult = 32'd0;
    mem_ready    = 1'b0;
    mem_readData = 32'd0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    step();
    total++;
    if ({stall, rd_w, writeData, regWrite, fwd_valid, fwd_reg, fwd_data} !== 76'd0) begin
      bad++;
      $display("FAIL reset_outputs: got stall=%b rd_w=%0d wd=%h rw=%b fv=%b fr=%0d fd=%h, want all zero",
               stall, rd_w, writeData, regWrite, fwd_valid, fwd_reg, fwd_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu_write;
    do_reset();
    in_valid = 1'b1; in_regWrite = 1'b1; in_memToReg = 1'b0;
    in_rd = 5'd1; in_aluResult = 32'h0003C00F;
    step();
    total++;
    if ({regWrite, rd_w, writeData, fwd_valid, fwd_reg, fwd_data, stall} !== {1'b1, 5'd1, 32'h0003C00F, 1'b1, 5'd1, 32'h0003C00F, 1'b0}) begin
      bad++;
      $display("FAIL alu_write: got rw=%b rd_w=%0d wd=%h fv=%b fr=%0d fd=%h stall=%b, want 1 1 0003c00f 1 1 0003c00f 0",
               regWrite, rd_w, writeData, fwd_valid, fwd_reg, fwd_data, stall);
    end
    idle_inputs();
    step();
    total++;
    if ({regWrite, fwd_valid, rd_w, writeData} !== {1'b0, 1'b0, 5'd1, 32'h0003C00F}) begin
      bad++;
      $display("FAIL alu_write_after: got rw=%b fv=%b rd_w=%0d wd=%h, want 0 0 1 0003c00f (held)",
               regWrite, fwd_valid, rd_w, writeData);
    end
  endtask

  task automatic test_load_delay;
    do_reset();
    in_valid = 1'b1; in_regWrite = 1'b1; in_memToReg = 1'b1; in_rd = 5'd5;
    in_aluResult = 32'h12345678;
    // Readiness in the capture cycle must be ignored
    mem_ready = 1'b1; mem_readData = 32'hBAD0BAD0;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({stall, regWrite, fwd_valid} !== 3'b100) begin
        bad++;
        $display("FAIL load_wait[%0d]: got stall=%b rw=%b fv=%b, want 1 0 0", i, stall, regWrite, fwd_valid);
      end
      if (i == 2) begin
        mem_ready = 1'b1; mem_readData = 32'h0000000F;
      end
      step();
    end
    mem_ready = 1'b0;
    total++;
    if ({regWrite, rd_w, writeData, stall, fwd_valid, fwd_reg, fwd_data} !== {1'b1, 5'd5, 32'h0000000F, 1'b0, 1'b1, 5'd5, 32'h0000000F}) begin
      bad++;
      $display("FAIL load_write: got rw=%b rd_w=%0d wd=%h stall=%b fv=%b fr=%0d fd=%h, want 1 5 0000000f 0 1 5 0000000f",
               regWrite, rd_w, writeData, stall, fwd_valid, fwd_reg, fwd_data);
    end
    step();
    total++;
    if (regWrite !== 1'b0) begin
      bad++;
      $display("FAIL load_single_pulse: got rw=%b, want 0", regWrite);
    end
  endtask

  task automatic test_zero_guard;
    do_reset();
    for (int m = 0; m < 3; m++) begin
      in_valid = 1'b1;
      in_regWrite = (m < 2);
      in_memToReg = (m == 1) || (m == 2);
      in_rd = (m < 2) ? 5'd0 : 5'd7;
      in_aluResult = 32'hFFFFFFFF;
      mem_ready = 1'b0;
      step();
      total++;
      if ({regWrite, stall, fwd_valid} !== 3'b000) begin
        bad++;
        $display("FAIL zero_guard[%0d]: got rw=%b stall=%b fv=%b, want 0 0 0", m, regWrite, stall, fwd_valid);
      end
    end
    idle_inputs();
    // mem_ready in IDLE produces nothing
    mem_ready = 1'b1; mem_readData = 32'hCAFEF00D;
    step();
    total++;
    if ({regWrite, stall} !== 2'b00) begin
      bad++;
      $display("FAIL idle_mem_ready: got rw=%b stall=%b, want 0 0", regWrite, stall);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset_mid_load;
    do_reset();
    in_valid = 1'b1; in_regWrite = 1'b1; in_memToReg = 1'b0; in_rd = 5'd6; in_aluResult = 32'h00000066;
    step();
    in_memToReg = 1'b1; in_rd = 5'd9;
    step();
    idle_inputs();
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL mid_load_stall: got stall=%b, want 1", stall);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({stall, rd_w, writeData, regWrite, fwd_valid, fwd_reg, fwd_data} !== 76'd0) begin
      bad++;
      $display("FAIL async_reset: got stall=%b rd_w=%0d wd=%h rw=%b fv=%b fr=%0d fd=%h, want all zero",
               stall, rd_w, writeData, regWrite, fwd_valid, fwd_reg, fwd_data);
    end
    rst = 1'b0;
    mem_ready = 1'b1; mem_readData = 32'hDEADBEEF;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({regWrite, stall, writeData} !== {1'b0, 1'b0, 32'd0}) begin
        bad++;
        $display("FAIL post_reset_no_write[%0d]: got rw=%b stall=%b wd=%h, want 0 0 00000000", i, regWrite, stall, writeData);
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back;
    logic [4:0]  got_rd[$];
    logic [31:0] got_wd[$];
    logic [4:0]  exp_rd[3];
    logic [31:0] exp_wd[3];
    exp_rd = '{5'd2, 5'd3, 5'd4};
    exp_wd = '{32'h1, 32'h00ABCDEF, 32'h4};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      case (c)
        0: begin in_valid = 1; in_regWrite = 1; in_rd = 5'd2; in_aluResult = 32'h1; end
        1: begin in_valid = 1; in_regWrite = 1; in_memToReg = 1; in_rd = 5'd3; in_aluResult = 32'h33; end
        2, 3, 4: begin in_valid = 1; in_regWrite = 1; in_rd = 5'd4; in_aluResult = 32'h4; end
        default: ;
      endcase
      if (c == 3) begin mem_ready = 1'b1; mem_readData = 32'h00ABCDEF; end
      step();
      if (regWrite === 1'b1) begin
        got_rd.push_back(rd_w);
        got_wd.push_back(writeData);
      end
    end
    total++;
    if (got_rd.size() != 3) begin
      bad++;
      $display("FAIL b2b_count: got %0d writes, want 3", got_rd.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if ({got_rd[i], got_wd[i]} !== {exp_rd[i], exp_wd[i]}) begin
          bad++;
          $display("FAIL b2b_write[%0d]: got r%0d=%h, want r%0d=%h", i, got_rd[i], got_wd[i], exp_rd[i], exp_wd[i]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_random;
    logic        busy, hold, e_rw;
    logic [4:0]  pend, e_rd;
    logic [31:0] e_wd;
    int          waited;
    busy = 0; hold = 0; pend = 0; e_rd = 0; e_wd = 0; waited = 0;
    idle_inputs();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        in_valid     = ($urandom_range(0, 3) != 0);
        in_regWrite  = ($urandom_range(0, 7) != 0);
        in_memToReg  = ($urandom_range(0, 2) == 0);
        in_rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        in_aluResult = $urandom;
      end
      // Keep load latency below the timeout so the model never sees one
      mem_ready    = busy ? ((waited >= 2) || ($urandom_range(0, 2) == 0)) : 1'($urandom_range(0, 1));
      mem_readData = $urandom;
      e_rw = 1'b0;
      if (busy) begin
        hold = in_valid;
        if (mem_ready) begin
          e_rw = 1'b1; e_rd = pend; e_wd = mem_readData; busy = 1'b0;
        end else begin
          waited++;
        end
      end else begin
        hold = 1'b0;
        if (in_valid && in_regWrite && in_rd != 5'd0) begin
          if (in_memToReg) begin
            busy = 1'b1; pend = in_rd; waited = 0;
          end else begin
            e_rw = 1'b1; e_rd = in_rd; e_wd = in_aluResult;
          end
        end
      end
      step();
      total++;
      if ({regWrite, rd_w, writeData, stall, fwd_valid} !== {e_rw, e_rd, e_wd, busy, e_rw}) begin
        bad++;
        $display("FAIL random[%0d]: got rw=%b rd_w=%0d wd=%h stall=%b fv=%b, want %b %0d %h %b %b",
                 n, regWrite, rd_w, writeData, stall, fwd_valid, e_rw, e_rd, e_wd, busy, e_rw);
      end
      if (e_rw) begin
        total++;
        if ({fwd_reg, fwd_data} !== {e_rd, e_wd}) begin
          bad++;
          $display("FAIL random_fwd[%0d]: got fr=%0d fd=%h, want %0d %h", n, fwd_reg, fwd_data, e_rd, e_wd);
        end
      end
    end
    idle_inputs();
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout;
    do_reset();
    in_valid = 1'b1; in_regWrite = 1'b1; in_memToReg = 1'b1; in_rd = 5'd12;
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({stall, timeout_err, regWrite} !== 3'b100) begin
        bad++;
        $display("FAIL timeout_wait[%0d]: got stall=%b err=%b rw=%b, want 1 0 0", i, stall, timeout_err, regWrite);
      end
      step();
    end
    total++;
    if ({stall, timeout_err, regWrite} !== 3'b010) begin
      bad++;
      $display("FAIL timeout_fire: got stall=%b err=%b rw=%b, want 0 1 0", stall, timeout_err, regWrite);
    end
    mem_ready = 1'b1; mem_readData = 32'h77777777;
    step();
    total++;
    if ({stall, timeout_err, regWrite} !== 3'b010) begin
      bad++;
      $display("FAIL timeout_sticky: got stall=%b err=%b rw=%b, want 0 1 0", stall, timeout_err, regWrite);
    end
    idle_inputs();
  endtask
`endif

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_alu_write();
    test_load_delay();
    test_zero_guard();
    test_async_reset_mid_load();
    test_back_to_back();
    test_random();
`ifdef WB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
